// File: rtl/axi_bridge_pkg.sv
// Shared types and AXI burst constants for the D-cache to AXI4 line bridge.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    DONE
  } bridge_state_e;

  localparam logic [7:0] BURST_LEN_M1   = 8'd3;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dcache_axi_bridge.sv
// Converts one 128-bit D-cache line request into a single 4-beat 32-bit AXI4 INCR burst.
// state | meaning
// IDLE  | waiting for dvalid; latches the request
// RADDR | AR presented
// RDATA | collecting four read beats into the line register
// WADDR | AW presented (always ahead of W)
// WDATA | sending four write beats from the latched line
// WRESP | waiting for the write response
// DONE  | one-cycle mready / merr pulse
module dcache_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dvalid,
  input  logic         wen,
  input  logic [31:0]  addr,
  input  logic [127:0] wdata,
  output logic         mready,
  output logic [127:0] rline,
  output logic         merr,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  bridge_state_e state_q, state_d;
  logic [1:0]    cnt_q;
  logic [31:0]   addr_q;
  logic [127:0]  line_q;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    mready  = 1'b0;
    case (state_q)
      IDLE:  if (dvalid) state_d = wen ? WADDR : RADDR;
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid && cnt_q == 2'd3) state_d = DONE;
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = WDATA;
      end
      WDATA: begin
        wvalid = 1'b1;
        if (wready && cnt_q == 2'd3) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        mready  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line register doubles as write source and read assembly buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      addr_q <= 32'd0;
      line_q <= 128'd0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (dvalid) begin
          addr_q <= addr & 32'hFFFF_FFF0;
          line_q <= wdata;
          cnt_q  <= 2'd0;
          err_q  <= 1'b0;
        end
        RDATA: if (rvalid) begin
          line_q[{cnt_q, 5'd0} +: 32] <= rdata;
          err_q <= err_q | (rresp != AXI_RESP_OKAY) | (rlast && cnt_q != 2'd3);
          cnt_q <= cnt_q + 2'd1;
        end
        WDATA: if (wready) cnt_q <= cnt_q + 2'd1;
        WRESP: if (bvalid) err_q <= err_q | (bresp != AXI_RESP_OKAY);
        default: ;
      endcase
    end
  end

  assign merr    = (state_q == DONE) && err_q;
  assign rline   = line_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = BURST_LEN_M1;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = BURST_LEN_M1;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;

  assign wdata_o = line_q[{cnt_q, 5'd0} +: 32];
  assign wstrb   = 4'hF;
  assign wlast   = (state_q == WDATA) && (cnt_q == 2'd3);

endmodule
